matmul_result_drain: RTL and testbench
======================================

MATMUL_RESULT_DRAIN -- requirements
Module: matmul_result_drain

Interface
REQ-001 Parameter CWIDTH, default 32, SHALL set the width of one result element (2x DWIDTH).
REQ-002 Parameter NUM_C, default 16, SHALL set the element count (4x4 array); the counter width SHALL be 4 bits.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 done_mat_mul  in  1  SHALL be the level-high completion flag from the systolic array.
REQ-006 matrix_c_flat  in  NUM_C*CWIDTH  SHALL carry the results, with element Cij at bits [(4i+j+1)*CWIDTH-1 : (4i+j)*CWIDTH].
REQ-007 c_ready  in  1  SHALL be the downstream ready.
REQ-008 c_valid  out  1  SHALL flag c_data as valid.
REQ-009 c_data  out  CWIDTH  SHALL be the current result element.
REQ-010 c_index  out  4  SHALL be the linear index 4i+j of c_data.
REQ-011 c_last  out  1  SHALL be high with the final element of a drain.
REQ-012 busy  out  1  SHALL be high while a captured matrix is not fully drained.
REQ-013 drain_done  out  1  SHALL pulse high for one cycle after the last handshake.
REQ-014 dropped  out  1  SHALL be a sticky flag indicating a completion was ignored.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, STREAM and FINISH.
REQ-016 A done_d register SHALL detect the rising edge of done_mat_mul; a held-high level SHALL NOT retrigger a drain.
REQ-017 In IDLE, a rising edge sampled at edge N SHALL copy all NUM_C elements into an internal buffer, clear the counter and enter STREAM, with c_valid high from cycle N+1.
REQ-018 In STREAM, c_valid SHALL be 1 and c_data SHALL equal buf[cnt]; the element order SHALL follow REQ-030.
REQ-019 A handshake SHALL occur on c_valid && c_ready; only a handshake SHALL advance cnt.
REQ-020 c_data, c_index and c_last SHALL remain stable while c_valid && !c_ready.
REQ-021 c_last SHALL be 1 iff cnt == NUM_C-1 in STREAM.
REQ-022 A handshake at cnt == NUM_C-1 SHALL enter FINISH; FINISH SHALL assert drain_done for one cycle and return to IDLE with c_valid = 0.
REQ-023 A rising edge of done_mat_mul in STREAM or FINISH SHALL leave the buffer unchanged and set dropped; dropped SHALL clear only on reset.
REQ-024 A rising edge in the same cycle as the FINISH-to-IDLE return SHALL be dropped (FINISH is not IDLE).
REQ-025 busy SHALL be 1 in STREAM and FINISH and 0 in IDLE.
REQ-026 Steady-state throughput SHALL be one element per cycle with c_ready held high, giving 16 beats followed by the drain_done cycle.
REQ-027 Data SHALL pass through unmodified, with no arithmetic or truncation.

Reset
REQ-028 While reset = 0, the following SHALL hold asynchronously: state = IDLE, c_valid = 0, c_data = 0, c_index = 0, c_last = 0, busy = 0, drain_done = 0, dropped = 0, done_d = 0 and the buffer = 0.
REQ-029 Reset asserted mid-drain SHALL abandon the drain with no drain_done; after release, a done_mat_mul level that is already high SHALL count as a rising edge only if it is sampled high with done_d = 0.

Configuration
REQ-030 Macro DRAIN_COL_MAJOR_EN:
- Defined: drain order SHALL be column-major (C00, C10, C20, C30, C01, ...), and c_index SHALL report 4i+j of the element actually output.
- Undefined: drain order SHALL be row-major (C00, C01, C02, C03, C10, ...).

Verification
REQ-031 Cij = 100*i+j with c_ready = 1 and done_mat_mul rising at cycle 10 -> c_valid at cycles 11..26; c_data = 0, 1, 2, 3, 100, ..., 303; c_last at cycle 26; drain_done at cycle 27.
REQ-032 c_ready = 0 for cycles 11..14, then 1 -> c_data holds 0 with c_index 0 through cycle 14; the drain completes at cycle 30.
REQ-033 done_mat_mul held high for 40 cycles -> exactly one drain, and dropped = 0.
REQ-034 Second done_mat_mul rising edge at cycle 15 with matrix_c_flat changed -> original data continues to drain, and dropped = 1 from cycle 16.
REQ-035 reset = 0 at cycle 18 mid-drain -> c_valid = 0 immediately, no drain_done, all outputs 0; a new rising edge restarts from c_index 0.
REQ-036 With DRAIN_COL_MAJOR_EN defined, stimulus of REQ-031 -> c_data = 0, 100, 200, 300, 1, ...; c_index = 0, 4, 8, 12, 1, ....

Source files
------------

// File: rtl/matmul_result_drain.sv
// matmul_result_drain: captures a 4x4 result matrix on the rising edge of
// done_mat_mul and streams it out one element per ready/valid handshake.
// Completions that arrive while a drain is in progress are ignored and
// recorded in the sticky 'dropped' flag.
// Optional build macro DRAIN_COL_MAJOR_EN selects column-major drain order;
// the default build drains row-major.
module matmul_result_drain #(
    parameter int CWIDTH = 32,
    parameter int NUM_C  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      done_mat_mul,
    input  logic [NUM_C*CWIDTH-1:0]   matrix_c_flat,
    input  logic                      c_ready,
    output logic                      c_valid,
    output logic [CWIDTH-1:0]         c_data,
    output logic [3:0]                c_index,
    output logic                      c_last,
    output logic                      busy,
    output logic                      drain_done,
    output logic                      dropped
);

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    localparam logic [3:0] LAST_CNT = 4'(NUM_C - 1);

    state_t                    state;
    logic                      done_d;
    logic [3:0]                cnt;
    logic [NUM_C*CWIDTH-1:0]   c_buf;

    logic                      done_rise;
    logic [3:0]                next_cnt;
    logic [3:0]                next_idx;

    // Map the beat number to the linear element index 4i+j it carries.
    function automatic logic [3:0] elem_index(input logic [3:0] k);
`ifdef DRAIN_COL_MAJOR_EN
        // beat k carries row k[1:0], column k[3:2]
        return {k[1:0], k[3:2]};
`else
        return k;
`endif
    endfunction

    assign done_rise = done_mat_mul & ~done_d;
    assign next_cnt  = cnt + 4'd1;
    assign next_idx  = elem_index(next_cnt);

    // Drain FSM: capture on completion edge, stream with registered outputs,
    // one FINISH cycle for the drain_done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            done_d     <= 1'b0;
            cnt        <= 4'd0;
            c_buf      <= '0;
            c_valid    <= 1'b0;
            c_data     <= '0;
            c_index    <= 4'd0;
            c_last     <= 1'b0;
            busy       <= 1'b0;
            drain_done <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            done_d <= done_mat_mul;
            case (state)
                IDLE: begin
                    drain_done <= 1'b0;
                    if (done_rise) begin
                        // The first element comes straight from the input
                        // since the buffer is loaded on this same edge.
                        c_buf   <= matrix_c_flat;
                        cnt     <= 4'd0;
                        c_data  <= matrix_c_flat[int'(elem_index(4'd0))*CWIDTH +: CWIDTH];
                        c_index <= elem_index(4'd0);
                        c_last  <= (LAST_CNT == 4'd0);
                        c_valid <= 1'b1;
                        busy    <= 1'b1;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (done_rise) begin
                        dropped <= 1'b1;
                    end
                    if (c_ready) begin
                        if (cnt == LAST_CNT) begin
                            c_valid    <= 1'b0;
                            c_last     <= 1'b0;
                            drain_done <= 1'b1;
                            state      <= FINISH;
                        end else begin
                            cnt     <= next_cnt;
                            c_data  <= c_buf[int'(next_idx)*CWIDTH +: CWIDTH];
                            c_index <= next_idx;
                            c_last  <= (next_cnt == LAST_CNT);
                        end
                    end
                end
                FINISH: begin
                    // A completion edge here is still dropped: not yet IDLE.
                    if (done_rise) begin
                        dropped <= 1'b1;
                    end
                    drain_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_result_drain.sv
// Testbench for matmul_result_drain: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_matmul_result_drain;

    localparam int CWIDTH = 32;
    localparam int NUM_C  = 16;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    done_mat_mul = 1'b0;
    logic [NUM_C*CWIDTH-1:0] matrix_c_flat = '0;
    logic                    c_ready = 1'b0;
    logic                    c_valid;
    logic [CWIDTH-1:0]       c_data;
    logic [3:0]              c_index;
    logic                    c_last;
    logic                    busy;
    logic                    drain_done;
    logic                    dropped;

    matmul_result_drain #(.CWIDTH(CWIDTH), .NUM_C(NUM_C)) dut (
        .clk           (clk),
        .reset         (reset),
        .done_mat_mul  (done_mat_mul),
        .matrix_c_flat (matrix_c_flat),
        .c_ready       (c_ready),
        .c_valid       (c_valid),
        .c_data        (c_data),
        .c_index       (c_index),
        .c_last        (c_last),
        .busy          (busy),
        .drain_done    (drain_done),
        .dropped       (dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CWIDTH-1:0] data;
        logic [3:0]        idx;
    } beat_t;

    // Reference model: pending beats of the current drain, finish cycle,
    // sticky drop flag and the previous completion level.
    beat_t q[$];
    bit    m_fin;
    bit    m_drop;
    bit    m_done_prev;
    bit    rise;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Queue the 16 beats of a captured matrix in drain order.
    task automatic capture_matrix();
        for (int k = 0; k < NUM_C; k++) begin
            beat_t b;
            int i, j;
`ifdef DRAIN_COL_MAJOR_EN
            i = k % 4;
            j = k / 4;
`else
            i = k / 4;
            j = k % 4;
`endif
            b.idx  = 4'(4 * i + j);
            b.data = matrix_c_flat[(4 * i + j) * CWIDTH +: CWIDTH];
            q.push_back(b);
        end
    endtask

    // Model update on each clock edge; cleared asynchronously by reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_fin       = 1'b0;
            m_drop      = 1'b0;
            m_done_prev = 1'b0;
        end else begin
            rise = done_mat_mul && !m_done_prev;
            if (m_fin) begin
                m_fin = 1'b0;
                if (rise) m_drop = 1'b1;
            end else if (q.size() > 0) begin
                if (rise) m_drop = 1'b1;
                if (c_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_fin = 1'b1;
                end
            end else if (rise) begin
                capture_matrix();
            end
            m_done_prev = done_mat_mul;
        end
    end

    task automatic check_outputs();
        check_eq("c_valid", c_valid, q.size() > 0);
        check_eq("busy", busy, (q.size() > 0) || m_fin);
        check_eq("drain_done", drain_done, m_fin);
        check_eq("dropped", dropped, m_drop);
        if (q.size() > 0) begin
            check_eq("c_data", c_data, q[0].data);
            check_eq("c_index", c_index, q[0].idx);
            check_eq("c_last", c_last, q.size() == 1);
        end
    endtask

    task automatic check_all_zero();
        check_eq("rst_c_valid", c_valid, 0);
        check_eq("rst_c_data", c_data, 0);
        check_eq("rst_c_index", c_index, 0);
        check_eq("rst_c_last", c_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_drain_done", drain_done, 0);
        check_eq("rst_dropped", dropped, 0);
    endtask

    // Advance to the next falling edge and compare against the model.
    task automatic step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                matrix_c_flat[(4 * i + j) * CWIDTH +: CWIDTH] = 32'(100 * i + j);
    endtask

    task automatic load_random();
        for (int k = 0; k < NUM_C; k++)
            matrix_c_flat[k * CWIDTH +: CWIDTH] = $urandom;
    endtask

    task automatic pulse_done();
        done_mat_mul = 1'b1;
        step();
        done_mat_mul = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero();
        reset = 1'b1;

        // Reference pattern with ready always high.
        load_pattern();
        c_ready = 1'b1;
        step();
        pulse_done();
        repeat (20) step();

        // Back-pressure at the start of a drain.
        c_ready = 1'b0;
        pulse_done();
        repeat (4) step();
        c_ready = 1'b1;
        repeat (20) step();

        // Completion level held high: one drain only.
        done_mat_mul = 1'b1;
        repeat (40) step();
        done_mat_mul = 1'b0;
        repeat (3) step();

        // Second completion mid-drain with new data.
        pulse_done();
        repeat (4) step();
        load_random();
        pulse_done();
        repeat (20) step();

        // Reset mid-drain: outputs clear at once, no drain_done.
        pulse_done();
        repeat (7) step();
        reset = 1'b0;
        #1;
        check_all_zero();
        @(negedge clk);
        check_all_zero();
        reset = 1'b1;
        pulse_done();
        repeat (20) step();

        // Completion coinciding with the FINISH-to-IDLE cycle is dropped.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        pulse_done();
        repeat (16) step();
        pulse_done();
        repeat (3) step();

        // Completion level already high at reset release starts a drain.
        reset = 1'b0;
        done_mat_mul = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        step();
        done_mat_mul = 1'b0;
        repeat (20) step();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            c_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) done_mat_mul = ~done_mat_mul;
            if ($urandom_range(0, 7) == 0) load_random();
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b0;
                #1;
                check_all_zero();
                @(negedge clk);
                reset = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
